// File: rtl/lapido_run_monitor_pkg.sv
// Shared encodings for the run monitor: FSM states and trace entry kinds.
package lapido_run_monitor_pkg;

    typedef enum logic [1:0] {
        MON_RUN    = 2'b00,
        MON_DRAIN  = 2'b01,
        MON_HALTED = 2'b10,
        MON_ERROR  = 2'b11
    } mon_state_e;

    typedef enum logic [1:0] {
        TRACE_NONE   = 2'b00,
        TRACE_JUMP   = 2'b01,
        TRACE_BRANCH = 2'b10
    } trace_kind_e;

    // Bits needed to hold the value n.
    function automatic int cnt_bits(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lapido_run_monitor_trace_fifo.sv
// Generic sync FIFO; write visible at next edge, head shown combinationally (zero when empty).
// Push on full is dropped (drop_o pulses) unless a pop happens the same cycle; pop on empty is ignored.
module lapido_run_monitor_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop frees the slot a same-cycle push on a full buffer needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/lapido_run_monitor.sv
// Run-control/trace monitor: halt detect + drain, taken-transfer trace log (1-cycle), OOB target flag.
// Trace overflow drops entries (sticky flag); LAPIDO_MON_STAMP_EN adds a cycle stamp to each entry.
module lapido_run_monitor
    import lapido_run_monitor_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int IMEM_WORDS   = 1024,
    parameter int TRACE_DEPTH  = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32,
`ifdef LAPIDO_MON_STAMP_EN
    localparam int TW = 2 + CNT_W + ADDR_W
`else
    localparam int TW = 2 + ADDR_W
`endif
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           id_is_jump_i,
    input  logic [ADDR_W-1:0]              id_jump_addr_i,
    input  logic [ADDR_W-1:0]              if_pc_i,
    input  logic                           mem_branch_taken_i,
    input  logic [ADDR_W-1:0]              mem_branch_addr_i,
    input  logic                           trace_rd_i,
    output logic [TW-1:0]                  trace_data_o,
    output logic                           trace_empty_o,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count_o,
    output logic                           trace_ovf_o,
    output logic [1:0]                     state_o,
    output logic                           halted_o,
    output logic                           oob_err_o,
    output logic [ADDR_W-1:0]              oob_addr_o
);

    localparam int DCW = cnt_bits(DRAIN_CYCLES);

    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TRACE_DEPTH must be a power of two >= 2");
    end
    if (DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("DRAIN_CYCLES and CNT_W must be >= 1");
    end

    mon_state_e        state_q;
    logic [DCW-1:0]    drain_q;
    logic              oob_err_q;
    logic [ADDR_W-1:0] oob_addr_q;
    logic              ovf_q;

    logic              ev_vld;
    trace_kind_e       ev_kind;
    logic [ADDR_W-1:0] ev_addr;
    logic              ev_oob;
    logic              halt_hit;
    logic              active;
    logic              push;
    logic              drop;
    logic [TW-1:0]     entry;

    // A taken branch in MEM flushes whatever jump ID resolved this cycle.
    always_comb begin
        ev_vld   = mem_branch_taken_i || id_is_jump_i;
        ev_kind  = TRACE_NONE;
        ev_addr  = '0;
        if (mem_branch_taken_i) begin
            ev_kind = TRACE_BRANCH;
            ev_addr = mem_branch_addr_i;
        end else if (id_is_jump_i) begin
            ev_kind = TRACE_JUMP;
            ev_addr = id_jump_addr_i;
        end
        ev_oob   = ev_vld && (ev_addr >= ADDR_W'(IMEM_WORDS));
        halt_hit = id_is_jump_i && !mem_branch_taken_i
                   && (id_jump_addr_i == if_pc_i - ADDR_W'(1));
        active   = (state_q == MON_RUN) || (state_q == MON_DRAIN);
        push     = active && ev_vld;
    end

`ifdef LAPIDO_MON_STAMP_EN
    logic [CNT_W-1:0] stamp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stamp_q <= '0;
        else         stamp_q <= stamp_q + CNT_W'(1);
    end

    assign entry = {ev_kind, stamp_q, ev_addr};
`else
    assign entry = {ev_kind, ev_addr};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= MON_RUN;
            drain_q    <= '0;
            oob_err_q  <= 1'b0;
            oob_addr_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            case (state_q)
                MON_RUN: begin
                    if (ev_oob) begin
                        state_q    <= MON_ERROR;
                        oob_err_q  <= 1'b1;
                        oob_addr_q <= ev_addr;
                    end else if (halt_hit) begin
                        state_q <= MON_DRAIN;
                        drain_q <= DCW'(DRAIN_CYCLES);
                    end
                end
                MON_DRAIN: begin
                    if (ev_oob) begin
                        state_q    <= MON_ERROR;
                        oob_err_q  <= 1'b1;
                        oob_addr_q <= ev_addr;
                    end else if (drain_q == DCW'(1)) begin
                        state_q <= MON_HALTED;
                        drain_q <= '0;
                    end else begin
                        drain_q <= drain_q - DCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    lapido_run_monitor_trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push),
        .push_dat_i (entry),
        .pop_i      (trace_rd_i),
        .head_dat_o (trace_data_o),
        .full_o     (),
        .empty_o    (trace_empty_o),
        .count_o    (trace_count_o),
        .drop_o     (drop)
    );

    assign trace_ovf_o = ovf_q;
    assign state_o     = state_q;
    assign halted_o    = (state_q == MON_HALTED);
    assign oob_err_o   = oob_err_q;
    assign oob_addr_o  = oob_addr_q;

endmodule
